// File: rtl/pixel_fetch_scheduler.sv
// Pixel fetch scheduler: walks the raster, handshakes each pixel colour with
// software over PIOs (4-phase req/ack), and buffers colours in a FWFT FIFO
// for the VGA scan-out side. A per-phase timeout keeps the display fed.
module pixel_fetch_scheduler #(
  parameter int          H_RES         = 640,
  parameter int          V_RES         = 480,
  parameter int          FIFO_DEPTH    = 16,
  parameter int          TIMEOUT       = 1023,
  parameter logic [23:0] DEFAULT_COLOR = 24'h000000
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          enable,
  input  logic                          frame_sync,
  output logic [31:0]                   req_position,
  output logic                          req_valid,
  input  logic [23:0]                   resp_color,
  input  logic                          resp_ack,
  input  logic                          rd_en,
  output logic [23:0]                   rd_color,
  output logic                          rd_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   timeout_count,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] TO_V    = 16'(TIMEOUT);
  localparam logic [15:0] X_LAST  = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST  = 16'(V_RES - 1);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_timer, r_x, r_y, r_to_cnt;
  logic [31:0]   r_pos;
  logic          r_fd;
  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level;

  logic          w_hit, w_full, w_push, w_pop, w_to_evt, w_start, w_last;
  logic [23:0]   w_push_color;

  assign w_hit  = (r_timer == TO_V);
  assign w_full = (r_level == DEPTH_V);
  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

  // State register; frame_sync abandons any transaction in flight
  always_ff @(posedge clk_clk) begin
    if (reset_reset)     r_state <= S_IDLE;
    else if (frame_sync) r_state <= S_IDLE;
    else                 r_state <= w_next;
  end

  // Next state: IDLE waits for a stale ack to clear before issuing a request
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable && !w_full && !resp_ack) w_next = S_REQ;
      S_REQ:   if (resp_ack || w_hit)              w_next = S_REL;
      S_REL:   if (!resp_ack || w_hit)             w_next = S_IDLE;
      default:                                     w_next = S_IDLE;
    endcase
  end

  // Outputs and strobes; req_valid is masked by reset so it drops immediately
  always_comb begin
    req_valid    = (r_state == S_REQ) && !reset_reset;
    busy         = (r_state != S_IDLE);
    w_start      = (r_state == S_IDLE) && (w_next == S_REQ);
    w_push       = (r_state == S_REQ) && (resp_ack || w_hit) && !frame_sync;
    w_push_color = resp_ack ? resp_color : DEFAULT_COLOR;
    w_to_evt     = !frame_sync && w_hit &&
                   (((r_state == S_REQ) && !resp_ack) || ((r_state == S_REL) && resp_ack));
    w_pop        = rd_en && !rd_empty && !frame_sync;
  end

  // Phase timer: counts while in REQ/RELEASE, clears on every state change
  always_ff @(posedge clk_clk) begin
    if (reset_reset || frame_sync)              r_timer <= '0;
    else if (w_next != r_state || r_state == S_IDLE) r_timer <= '0;
    else                                        r_timer <= r_timer + 16'd1;
  end

  // Position latched at request start and held through the handshake
  always_ff @(posedge clk_clk) begin
    if (reset_reset)                 r_pos <= '0;
    else if (!frame_sync && w_start) r_pos <= {r_y, r_x};
  end

  // Raster walk advances on each push; frame_done marks the last pixel
  always_ff @(posedge clk_clk) begin
    if (reset_reset || frame_sync) begin
      r_x  <= '0;
      r_y  <= '0;
      r_fd <= 1'b0;
    end else begin
      r_fd <= w_push && w_last;
      if (w_push) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? 16'd0 : r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
    end
  end

  // Saturating timeout event counter; survives frame_sync
  always_ff @(posedge clk_clk) begin
    if (reset_reset)                         r_to_cnt <= '0;
    else if (w_to_evt && r_to_cnt != 16'hFFFF) r_to_cnt <= r_to_cnt + 16'd1;
  end

  // FIFO storage, no reset needed since reads are masked when empty
  always_ff @(posedge clk_clk) begin
    if (w_push) r_mem[r_wp] <= w_push_color;
  end

  // FIFO pointers and level; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk_clk) begin
    if (reset_reset || frame_sync) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_level <= r_level + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end
  end

  assign rd_empty      = (r_level == '0);
  assign rd_color      = rd_empty ? 24'h0 : r_mem[r_rp];
  assign fifo_level    = r_level;
  assign timeout_count = r_to_cnt;
  assign frame_done    = r_fd;
  assign req_position  = r_pos;

endmodule

// File: tb/tb_pixel_fetch_scheduler.sv
// Bench for pixel_fetch_scheduler: a randomized software responder drives the
// handshake while a queue-based reference model predicts every output.
module tb_pixel_fetch_scheduler;

  localparam int          H   = 4;
  localparam int          V   = 2;
  localparam int          D   = 16;
  localparam int          TO  = 20;
  localparam logic [23:0] DEF = 24'hABCDEF;

  logic        clk_clk = 1'b0;
  logic        reset_reset, enable, frame_sync, resp_ack, rd_en;
  logic [23:0] resp_color;
  logic [31:0] req_position;
  logic        req_valid, rd_empty, frame_done, busy;
  logic [23:0] rd_color;
  logic [4:0]  fifo_level;
  logic [15:0] timeout_count;

  pixel_fetch_scheduler #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .TIMEOUT(TO),
                          .DEFAULT_COLOR(DEF)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable), .frame_sync(frame_sync),
    .req_position(req_position), .req_valid(req_valid), .resp_color(resp_color),
    .resp_ack(resp_ack), .rd_en(rd_en), .rd_color(rd_color), .rd_empty(rd_empty),
    .fifo_level(fifo_level), .timeout_count(timeout_count), .frame_done(frame_done),
    .busy(busy));

  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: handshake phase (0 idle, 1 requesting, 2 releasing)
  int          m_ph = 0, m_tmr = 0, m_x = 0, m_y = 0, m_tc = 0;
  logic [31:0] m_pos = 0;
  logic [23:0] m_q[$];
  bit          m_fd = 0;

  // stimulus knobs and responder state
  int rd_pct = 0, en_pct = 100, fs_pm = 0;
  int dly_lo = 3, dly_hi = 3, hold_lo = 0, hold_hi = 0;
  bit col_xp1 = 1, fs_force = 0, rst_force = 0;
  int r_wait = 0, r_dly = 0, r_hold = 0, r_hc = 0;
  int rv_run = 0, last_run = 0, fd_cnt = 0;
  bit ack_fell = 0;

  function automatic int sat_inc(input int v);
    return (v == 65535) ? v : v + 1;
  endfunction

  task automatic mstep();
    bit          push, pop;
    logic [23:0] pc;
    int          nph;
    push = 0; pc = '0; nph = m_ph;
    if (reset_reset) begin
      m_ph = 0; m_tmr = 0; m_x = 0; m_y = 0; m_pos = 0; m_tc = 0; m_fd = 0;
      m_q.delete();
    end else if (frame_sync) begin
      m_ph = 0; m_tmr = 0; m_x = 0; m_y = 0; m_fd = 0;
      m_q.delete();
    end else begin
      pop  = rd_en && (m_q.size() > 0);
      m_fd = 0;
      case (m_ph)
        0: if (enable && m_q.size() < D && !resp_ack) begin
             nph = 1; m_pos = {16'(m_y), 16'(m_x)};
           end
        1: if (resp_ack) begin push = 1; pc = resp_color; nph = 2; end
           else if (m_tmr == TO) begin push = 1; pc = DEF; m_tc = sat_inc(m_tc); nph = 2; end
        default: if (!resp_ack) nph = 0;
                 else if (m_tmr == TO) begin m_tc = sat_inc(m_tc); nph = 0; end
      endcase
      m_tmr = (nph != m_ph || nph == 0) ? 0 : m_tmr + 1;
      m_ph  = nph;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(pc);
        if (m_x == H - 1) begin
          m_x = 0;
          if (m_y == V - 1) begin m_y = 0; m_fd = 1; end
          else m_y++;
        end else m_x++;
      end
    end
  endtask

  // one clock: compare at negedge, pick inputs, advance model, step clock
  task automatic cycle();
    bit rv_obs;
    chk("req_valid",     32'(req_valid),     32'(m_ph == 1));
    chk("busy",          32'(busy),          32'(m_ph != 0));
    chk("req_position",  req_position,       m_pos);
    chk("fifo_level",    32'(fifo_level),    32'(m_q.size()));
    chk("rd_empty",      32'(rd_empty),      32'(m_q.size() == 0));
    chk("rd_color",      32'(rd_color),      32'(m_q.size() > 0 ? m_q[0] : 24'h0));
    chk("timeout_count", 32'(timeout_count), 32'(m_tc));
    chk("frame_done",    32'(frame_done),    32'(m_fd));
    rv_obs = req_valid;
    if (frame_done) fd_cnt++;
    if (rv_obs) rv_run++;
    else begin
      if (rv_run > 0) last_run = rv_run;
      rv_run = 0;
    end
    reset_reset = rst_force;
    frame_sync  = fs_force || ($urandom_range(999) < fs_pm);
    enable      = ($urandom_range(99) < en_pct);
    rd_en       = ($urandom_range(99) < rd_pct);
    ack_fell    = 0;
    if (reset_reset || frame_sync) begin
      resp_ack = 0; r_wait = 0; r_hc = 0;
    end else if (rv_obs) begin
      if (r_wait == 0) begin
        r_dly  = $urandom_range(dly_hi, dly_lo);
        r_hold = $urandom_range(hold_hi, hold_lo);
      end
      r_wait++;
      if (!resp_ack && r_wait > r_dly) begin
        resp_ack   = 1;
        resp_color = col_xp1 ? {8'h0, req_position[15:0] + 16'd1} : 24'($urandom);
      end
    end else if (resp_ack) begin
      r_hc++;
      if (r_hc > r_hold) begin resp_ack = 0; ack_fell = 1; end
    end else begin
      r_wait = 0; r_hc = 0;
    end
    if (!resp_ack) resp_color = 24'($urandom);
    if (reset_reset) begin
      #1;
      chk("rst_rv_same_cycle", 32'(req_valid), 32'd0);
    end
    mstep();
    @(posedge clk_clk);
    @(negedge clk_clk);
  endtask

  task automatic drain();
    en_pct = 0; rd_pct = 100;
    repeat (60) cycle();
    last_run = 0;
  endtask

  int tc_base, npop;
  bit hit;

  initial begin
    reset_reset = 1; enable = 0; frame_sync = 0; resp_ack = 0; rd_en = 0; resp_color = 0;
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    rst_force = 1; cycle(); rst_force = 0;

    // fill: ack 3 cycles after strobe, colour = x+1, no pops
    fd_cnt = 0;
    repeat (200) cycle();
    chk("fill_level16", 32'(fifo_level), 32'd16);
    chk("full_no_req",  32'(req_valid),  32'd0);
    chk("fill_fd_cnt",  32'(fd_cnt),     32'd2);

    // continuous pop: colours follow the 4-pixel raster
    rd_pct = 100; npop = 0;
    for (int i = 0; i < 100; i++) begin
      if (!rd_empty && npop < 8) begin
        chk($sformatf("pop_seq%0d", npop), 32'(rd_color), 32'((npop % 4) + 1));
        npop++;
      end
      cycle();
    end

    // software never acks: one REQ timeout
    col_xp1 = 0;
    drain();
    dly_lo = 100; dly_hi = 100; hold_lo = 0; hold_hi = 0; en_pct = 100; rd_pct = 50;
    tc_base = m_tc; hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin cycle(); hit = (last_run != 0); end
    chk("to_seen",  32'(hit),           32'd1);
    chk("to_len",   32'(last_run),      32'(TO + 1));
    chk("to_count", 32'(timeout_count), 32'(tc_base + 1));

    // ack held through RELEASE past the timeout
    drain();
    dly_lo = 0; dly_hi = 2; hold_lo = 40; hold_hi = 40; en_pct = 100; rd_pct = 50;
    tc_base = m_tc; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin cycle(); hit = ack_fell; end
    chk("rel_ack_fell", 32'(hit),           32'd1);
    chk("rel_to_count", 32'(timeout_count), 32'(tc_base + 1));

    // frame_sync while requesting with 5 entries queued
    drain();
    dly_lo = 3; dly_hi = 3; hold_lo = 0; hold_hi = 0; en_pct = 100; rd_pct = 0;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      cycle();
      hit = (fifo_level == 5) && req_valid;
    end
    chk("fs_setup", 32'(hit), 32'd1);
    fs_force = 1; cycle(); fs_force = 0;
    chk("fs_level", 32'(fifo_level), 32'd0);
    chk("fs_empty", 32'(rd_empty),   32'd1);
    chk("fs_rv",    32'(req_valid),  32'd0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin cycle(); hit = req_valid; end
    chk("fs_next_req", 32'(hit),      32'd1);
    chk("fs_next_pos", req_position,  32'd0);

    // random soak with occasional timeouts and frame_sync pulses
    dly_lo = 0; dly_hi = 25; hold_lo = 0; hold_hi = 25;
    en_pct = 90; rd_pct = 40; fs_pm = 3;
    repeat (4000) cycle();
    fs_pm = 0;

    // reset in the middle of a request
    dly_lo = 10; dly_hi = 10; hold_lo = 0; hold_hi = 0; en_pct = 100;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin cycle(); hit = req_valid; end
    chk("rst_setup", 32'(hit), 32'd1);
    rst_force = 1; cycle(); rst_force = 0;
    en_pct = 0; rd_pct = 100;
    repeat (3) cycle();
    chk("rst_pop_level", 32'(fifo_level),    32'd0);
    chk("rst_tc",        32'(timeout_count), 32'd0);
    chk("rst_pos",       req_position,       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_fetch_scheduler.md
Name: pixel_fetch_scheduler

Overview:
- Sequences pixel-colour fetches from the NIOS II software renderer over the pixel PIOs.
- Walks the raster in order and drives the pixel-position and request PIO inputs.
- Runs a 4-phase handshake against the colour PIO output plus an ack PIO bit, and buffers returned colours in a FWFT FIFO.
- The VGA scan-out logic pops colours from the FIFO; a timeout keeps the display fed if software stalls.

Parameters:
- H_RES, 640, pixels per line; x range 0..H_RES-1.
- V_RES, 480, lines per frame; y range 0..V_RES-1.
- FIFO_DEPTH, 16, colour FIFO entries; must be a power of two and at least 2.
- TIMEOUT, 1023, cycles to wait for each handshake phase before forcing completion.
- DEFAULT_COLOR, 24'h000000, colour pushed when a request times out.

Ports:
- clk_clk, in, 1, system clock; single clock domain.
- reset_reset, in, 1, synchronous, active-high reset.
- enable, in, 1, allows new requests to start.
- frame_sync, in, 1, one-cycle pulse: restart the raster at (0,0) and flush the FIFO.
- req_position, out, 32, {y[15:0], x[15:0]}; drives pio_pixel_position.
- req_valid, out, 1, request strobe; drives pio_request.
- resp_color, in, 24, RGB from pio_pixel_color.
- resp_ack, in, 1, software ack bit from a PIO.
- rd_en, in, 1, pop request from the display side.
- rd_color, out, 24, head of the FIFO; valid when rd_empty=0.
- rd_empty, out, 1, FIFO empty flag.
- fifo_level, out, clog2(FIFO_DEPTH)+1, current entry count.
- timeout_count, out, 16, saturating count of timeout events.
- frame_done, out, 1, one-cycle pulse when the last pixel of a frame is pushed.
- busy, out, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: req_position=0, req_valid=0, rd_color=0, rd_empty=1, fifo_level=0, timeout_count=0, frame_done=0, busy=0. Internally x=y=0, FSM=IDLE, timer=0.
- FSM has three states: IDLE, REQ, RELEASE.
- IDLE:
  - req_valid=0.
  - Moves to REQ when enable=1, fifo_level<FIFO_DEPTH and resp_ack=0.
  - req_position={y,x} is registered on entry to REQ and held stable throughout REQ.
- REQ:
  - req_valid=1; the timer increments each cycle.
  - If resp_ack=1: push resp_color as sampled that cycle, go to RELEASE.
  - Else if timer==TIMEOUT: push DEFAULT_COLOR, increment timeout_count (saturating at 16'hFFFF), go to RELEASE.
  - The timer clears on every state change.
- RELEASE:
  - req_valid=0.
  - Moves to IDLE when resp_ack=0.
  - Else on timer==TIMEOUT: increment timeout_count and go to IDLE.
- Raster advance happens on the push cycle:
  - x=x+1.
  - If x was H_RES-1: x=0, y=y+1.
  - If additionally y was V_RES-1: y=0 and frame_done=1 for one cycle.
- Request-to-push latency is at least 1 cycle after resp_ack is seen high. The minimum full transaction is 4 cycles: IDLE, REQ, RELEASE, IDLE.
- FIFO:
  - First-word-fall-through: rd_color shows the head when non-empty.
  - A push can never occur when full, because IDLE gates on the level.
  - A pop with rd_empty=1 is ignored; no underflow and no level change.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- frame_sync (priority below reset, above everything else):
  - Next cycle: FSM=IDLE, req_valid=0, x=y=0, timer=0, FIFO flushed (level=0, rd_empty=1).
  - timeout_count is not cleared.
  - A push or pop coinciding with frame_sync is discarded.
- enable=0 mid-transaction: the current REQ/RELEASE completes normally, then the FSM stays in IDLE.
- Reset mid-operation: req_valid drops in the same cycle reset is sampled, and all state returns to reset values.
- resp_ack already high in IDLE: no new request starts until it falls; this guards against stale acks.

Test Plan:
- Reset, enable=1, bench acks each request 3 cycles after req_valid with colour = x+1 -> positions 0x00000000, 0x00000001, ... in order; FIFO fills to 16, then req_valid stays 0 until a pop.
- Pop continuously with H_RES=4, V_RES=2 -> rd_color sequence 1,2,3,4,1,2,3,4; frame_done pulses once on the 8th push; next req_position=0x00000000.
- Never assert resp_ack -> req_valid high for TIMEOUT+1 cycles, DEFAULT_COLOR pushed, timeout_count=1, raster advanced to x=1.
- Hold resp_ack high through RELEASE -> timeout_count increments after TIMEOUT cycles; the next request waits for resp_ack=0.
- frame_sync pulse in REQ with 5 entries queued -> next cycle fifo_level=0, rd_empty=1, req_valid=0; next request position 0x00000000.
- Assert reset_reset during REQ -> req_valid=0 and all outputs at reset values on the following cycle; rd_en on an empty FIFO leaves fifo_level=0.
